// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Button debounce and IDLE/RUN/PAUSE sequencing for the stopwatch.
//            Produces run enable, lap-capture and clear strobes, lap count and
//            the lap-recall view index consumed by the stopwatch datapath.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_LAPS        = 11,
  parameter int IDX_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_lap,
  input  logic             btn_clear,
  output logic             run,
  output logic             lap_stb,
  output logic [IDX_W-1:0] lap_idx,
  output logic             clear_stb,
  output logic [IDX_W-1:0] view_idx,
  output logic [IDX_W-1:0] lap_cnt,
  output logic             laps_full,
  output logic [1:0]       state
);

  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAPS_MAX = IDX_W'(MAX_LAPS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  // Bit 0 = start, bit 1 = lap, bit 2 = clear
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_clear, btn_lap, btn_start};

  generate
    for (genvar b = 0; b < 3; b++) begin : g_btn
      logic             sync1;
      logic             sync2;
      logic             deb;
      logic             deb_q;
      logic [CNT_W-1:0] cnt;

      // Synchronise the raw button and accept a new level only after it has been stable long enough
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1 <= 1'b1;
          sync2 <= 1'b1;
          deb   <= 1'b1;
          deb_q <= 1'b1;
          cnt   <= '0;
        end else begin
          sync1 <= btn_raw[b];
          sync2 <= sync1;
          deb_q <= deb;
          if (sync2 == deb) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            deb <= ~deb;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      // Press is the registered debounced level falling; releases are ignored
      assign press[b] = deb_q & ~deb;
    end
  endgenerate

  // One event per cycle: clear beats start beats lap
  logic ev_clear;
  logic ev_start;
  logic ev_lap;

  assign ev_clear = press[2];
  assign ev_start = press[0] & ~press[2];
  assign ev_lap   = press[1] & ~press[0] & ~press[2];

  state_t           cur_state;
  state_t           nxt_state;
  logic             run_n;
  logic             lap_stb_n;
  logic [IDX_W-1:0] lap_idx_n;
  logic             clear_stb_n;
  logic [IDX_W-1:0] view_n;
  logic [IDX_W-1:0] cnt_n;
  logic             full_n;

  // State and all datapath-facing outputs are registered together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= ST_IDLE;
      run       <= 1'b0;
      lap_stb   <= 1'b0;
      lap_idx   <= '0;
      clear_stb <= 1'b0;
      view_idx  <= '0;
      lap_cnt   <= '0;
      laps_full <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      run       <= run_n;
      lap_stb   <= lap_stb_n;
      lap_idx   <= lap_idx_n;
      clear_stb <= clear_stb_n;
      view_idx  <= view_n;
      lap_cnt   <= cnt_n;
      laps_full <= full_n;
    end
  end

  // Next-state and next-output decode from the arbitrated button event
  always_comb begin
    nxt_state   = cur_state;
    lap_stb_n   = 1'b0;
    clear_stb_n = 1'b0;
    lap_idx_n   = lap_idx;
    view_n      = view_idx;
    cnt_n       = lap_cnt;
    full_n      = laps_full;
    case (cur_state)
      ST_IDLE: begin
        if (ev_clear) begin
          clear_stb_n = 1'b1;
          cnt_n       = '0;
          view_n      = '0;
          full_n      = 1'b0;
        end else if (ev_start) begin
          nxt_state = ST_RUN;
        end
      end
      ST_RUN: begin
        view_n = '0;
        if (ev_start) begin
          nxt_state = ST_PAUSE;
        end else if (ev_lap && !laps_full) begin
          lap_stb_n = 1'b1;
          lap_idx_n = lap_cnt + 1'b1;
          cnt_n     = lap_cnt + 1'b1;
          full_n    = ((lap_cnt + 1'b1) == LAPS_MAX);
        end
      end
      ST_PAUSE: begin
        if (ev_clear) begin
          nxt_state   = ST_IDLE;
          clear_stb_n = 1'b1;
          cnt_n       = '0;
          view_n      = '0;
          full_n      = 1'b0;
        end else if (ev_start) begin
          nxt_state = ST_RUN;
          view_n    = '0;
        end else if (ev_lap) begin
          view_n = (view_idx == lap_cnt) ? '0 : view_idx + 1'b1;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
    run_n = (nxt_state == ST_RUN);
  end

  assign state = cur_state;

endmodule
`default_nettype wire
